// File: rtl/ga_pkg.sv
// Shared GA constants and the pop_reader state type.
package ga_pkg;

  localparam int unsigned POP_BITS  = 7500;
  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned NUM_BYTES = (POP_BITS + BYTE_W - 1) / BYTE_W;
  localparam int unsigned PAD       = NUM_BYTES * BYTE_W - POP_BITS;
  localparam int unsigned CNT_W     = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    CSUM   = 2'd2,
    DONE   = 2'd3
  } pop_reader_state_t;

endpackage

// File: rtl/pop_reader.sv
// Snapshots the population on start and streams it out oldest byte first over valid/ready.
// Optional trailing checksum byte when POP_READER_CHECKSUM_EN is defined.
module pop_reader
  import ga_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [POP_BITS-1:0] population,
  output logic [BYTE_W-1:0]   byte_out,
  output logic                byte_valid,
  input  logic                byte_ready,
  output logic                byte_last,
  output logic                busy,
  output logic                done
);

  localparam int unsigned      SH_W     = NUM_BYTES * BYTE_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_BYTES - 1);

  pop_reader_state_t r_state;
  logic [SH_W-1:0]   r_shadow;
  logic [CNT_W-1:0]  r_count;

  logic              w_hs;
  logic              w_last_data;
  logic [BYTE_W-1:0] w_top;

  assign w_top       = r_shadow[SH_W-1 -: BYTE_W];
  assign w_last_data = (r_count == LAST_IDX);
  assign w_hs        = byte_valid & byte_ready;

  // Zero-extension places the PAD zero bits above the population MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_shadow <= '0;
      r_count  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state  <= STREAM;
            r_shadow <= SH_W'(population);
            r_count  <= '0;
          end
        end
        STREAM: begin
          if (w_hs) begin
            r_shadow <= r_shadow << BYTE_W;
            r_count  <= r_count + 1'b1;
            if (w_last_data) begin
`ifdef POP_READER_CHECKSUM_EN
              r_state <= CSUM;
`else
              r_state <= DONE;
`endif
            end
          end
        end
`ifdef POP_READER_CHECKSUM_EN
        CSUM: begin
          if (w_hs) r_state <= DONE;
        end
`endif
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef POP_READER_CHECKSUM_EN
  logic [BYTE_W-1:0] r_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum <= '0;
    end else if (r_state == IDLE && start) begin
      r_sum <= '0;
    end else if (r_state == STREAM && w_hs) begin
      r_sum <= r_sum + w_top;
    end
  end

  always_comb begin
    byte_valid = (r_state == STREAM) || (r_state == CSUM);
    byte_out   = (r_state == CSUM) ? r_sum : w_top;
    byte_last  = (r_state == CSUM);
  end
`else
  // Shadow drains to zero as it shifts, so byte_out idles at 0 without a mux.
  always_comb begin
    byte_valid = (r_state == STREAM);
    byte_out   = w_top;
    byte_last  = (r_state == STREAM) && w_last_data;
  end
`endif

  assign busy = (r_state == STREAM);
  assign done = (r_state == DONE);

endmodule

// File: tb/tb_pop_reader.sv
// Scoreboard bench for pop_reader: stimulus pushes expected bytes, a monitor pops on each handshake.
module tb_pop_reader;

  localparam int NB = 938;
`ifdef POP_READER_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif
  localparam int STREAM_LEN = NB + (CS_EN ? 1 : 0);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7499:0] population;
  logic [7:0]    byte_out;
  logic          byte_valid;
  logic          byte_ready;
  logic          byte_last;
  logic          busy;
  logic          done;

  pop_reader u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .population (population),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_acc = 0;

  logic [8:0]    exp_q[$];
  logic [7:0]    src_bytes[NB];
  logic [7499:0] pop_src;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte 0 carries only the low nibble of the first written byte (4 pad bits above it).
  task automatic build_pop();
    pop_src = '0;
    pop_src[7499 -: 4] = src_bytes[0][3:0];
    for (int j = 1; j < NB; j++) pop_src[7495 - 8*(j-1) -: 8] = src_bytes[j];
  endtask

  task automatic load_expected();
    logic [7:0] b;
    logic [7:0] sum;
    sum = 8'h00;
    for (int j = 0; j < NB; j++) begin
      b = (j == 0) ? (src_bytes[0] & 8'h0F) : src_bytes[j];
      sum = sum + b;
      exp_q.push_back({(j == NB-1) && !CS_EN, b});
    end
    if (CS_EN) exp_q.push_back({1'b1, sum});
  endtask

  function automatic logic pick_ready(input int rmode);
    if (rmode == 0) return 1'b1;
    return ($urandom_range(0, 99) < 30);
  endfunction

  // Monitor: pops on handshake, checks hold-stability across stalls.
  logic       stall_prev = 1'b0;
  logic [7:0] held_byte;
  logic       held_last;
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, byte_valid}, 32'd1);
        chk("stall_byte",  {24'd0, byte_out},  {24'd0, held_byte});
        chk("stall_last",  {31'd0, byte_last}, {31'd0, held_last});
      end
      if (byte_valid && byte_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", {24'd0, byte_out}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("byte", {23'd0, byte_last, byte_out}, {23'd0, e});
        end
      end
      stall_prev = byte_valid && !byte_ready;
      held_byte  = byte_out;
      held_last  = byte_last;
    end
  end

  // One full readout; caller has filled src_bytes. Entered and left at posedge+1.
  task automatic run_stream(input int rmode, input bit snap_zero, input bit poke);
    int cyc;
    int first_done;
    int base;
    bit poked;
    build_pop();
    population = pop_src;
    load_expected();
    base = n_acc;
    start = 1'b1;
    byte_ready = pick_ready(rmode);
    @(posedge clk); #1;
    start = 1'b0;
    chk("valid_latency", {31'd0, byte_valid}, 32'd1);
    chk("busy_in_stream", {31'd0, busy}, 32'd1);
    if (snap_zero) population = '0;
    cyc = 0;
    first_done = -1;
    poked = 1'b0;
    while (cyc < 10000 && first_done < 0) begin
      byte_ready = pick_ready(rmode);
      start = 1'b0;
      if (poke && !poked && n_acc == base + 500) begin
        start = 1'b1;
        poked = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
      if (done) first_done = cyc;
    end
    chk("done_seen", {31'd0, first_done > 0}, 32'd1);
    if (rmode == 0) chk("done_latency", first_done, STREAM_LEN);
    chk("accept_total", n_acc - base, STREAM_LEN);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_valid_in_done", {31'd0, byte_valid}, 32'd0);
    start = poke;
    @(posedge clk); #1;
    start = 1'b0;
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("no_restart_from_done", {31'd0, busy}, 32'd0);
    @(posedge clk); #1;
    chk("still_idle", {30'd0, byte_valid, busy}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int base;
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    byte_ready = 1'b0;
    population = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
    chk("rst_flags", {28'd0, byte_valid, byte_last, busy, done}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Incrementing written bytes, continuous ready.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'(j + 1);
    run_stream(0, 1'b0, 1'b0);

    // All ones.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'hFF;
    run_stream(0, 1'b0, 1'b0);

    // Backpressure with distinct bytes so drops/duplicates show.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'((j * 37 + 11) ^ (j >> 8));
    run_stream(1, 1'b0, 1'b0);

    // Snapshot isolation.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'(8'hA5 ^ j);
    run_stream(0, 1'b1, 1'b0);

    // Start at byte 500 and during DONE.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'(255 - j);
    run_stream(0, 1'b0, 1'b1);

    // Reset after 100 accepted bytes.
    for (int j = 0; j < NB; j++) src_bytes[j] = 8'(j + 1);
    build_pop();
    population = pop_src;
    load_expected();
    base = n_acc;
    start = 1'b1;
    byte_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (cyc < 2000 && n_acc < base + 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("reached_100", n_acc - base, 100);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("async_rst_flags", {29'd0, byte_last, busy, done}, 32'd0);
    exp_q.delete();
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", {31'd0, done}, 32'd0);
    end
    run_stream(0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
